// File: rtl/sprite_layer_mixer.sv
`default_nettype none
// ============================================================================
// Module      : sprite_layer_mixer
// Description : Final compositing stage between the per-sprite renderers and
//               the VGA pins. Re-aligns each layer's combinational alpha flag
//               with its registered RGB, selects the highest-priority opaque
//               and enabled layer for every pixel (falling back to the
//               background colour), and delays hsync/vsync/blank by the same
//               two-cycle latency as the colour path. Per-layer enables are
//               taken from layer_en_req only on the falling edge of vsync so
//               that a sprite can never be switched on or off mid-frame.
//
//               Optional feature macro: SPRITE_MIXER_FLASH_EN
//                 Defined   - flash_req starts a hit flash lasting
//                             FLASH_FRAMES frames; red is boosted by +6
//                             (saturating at 15) while it is running.
//                 Undefined - flash_req is ignored, red passes unmodified.
//
// Ports       : vga_clk       pixel clock
//               reset_n       asynchronous active-low reset
//               blank         1 = active video (same timing as DrawX/DrawY)
//               hs, vs        active-low syncs, aligned with blank
//               layer_rgb     per-layer {r,g,b}; layer k at [12k+11:12k]
//               layer_a       per-layer alpha, one cycle ahead of layer_rgb
//               layer_en_req  requested layer enables (sampled per frame)
//               bg_rgb        background colour, timed like layer_rgb
//               flash_req     single-cycle hit-flash trigger
//               red/green/blue  VGA colour outputs
//               hs_out, vs_out, blank_out  syncs/blank delayed by 2 cycles
//               top_layer     winning layer index, NUM_LAYERS = background
//               frame_count   falling vsync edges seen since reset
//
// Revision    : 1.0 - initial release
// ============================================================================
module sprite_layer_mixer #(
  parameter int NUM_LAYERS   = 4,
  parameter int FLASH_FRAMES = 8
) (
  input  logic                         vga_clk,
  input  logic                         reset_n,
  input  logic                         blank,
  input  logic                         hs,
  input  logic                         vs,
  input  logic [NUM_LAYERS*12-1:0]     layer_rgb,
  input  logic [NUM_LAYERS-1:0]        layer_a,
  input  logic [NUM_LAYERS-1:0]        layer_en_req,
  input  logic [11:0]                  bg_rgb,
  input  logic                         flash_req,
  output logic [3:0]                   red,
  output logic [3:0]                   green,
  output logic [3:0]                   blue,
  output logic                         hs_out,
  output logic                         vs_out,
  output logic                         blank_out,
  output logic [$clog2(NUM_LAYERS):0]  top_layer,
  output logic [15:0]                  frame_count
);

  localparam int                IDX_W  = $clog2(NUM_LAYERS) + 1;
  localparam logic [IDX_W-1:0]  BG_IDX = IDX_W'(NUM_LAYERS);

  // --------------------------------------------------------------------------
  // Stage 1: alpha alignment and sync/blank tap 1
  // --------------------------------------------------------------------------
  logic [NUM_LAYERS-1:0] a_q;
  logic                  blank_t1;
  logic                  hs_t1;
  // vs_q doubles as the vsync pipeline tap and the edge-detect history.
  logic                  vs_q;

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      a_q      <= '0;
      blank_t1 <= 1'b0;
      hs_t1    <= 1'b1;
      vs_q     <= 1'b1;
    end else begin
      a_q      <= layer_a;
      blank_t1 <= blank;
      hs_t1    <= hs;
      vs_q     <= vs;
    end
  end

  // One pulse per high-to-low vsync transition, however long vs stays low.
  logic vs_fall;
  assign vs_fall = vs_q & ~vs;

  // --------------------------------------------------------------------------
  // Frame-boundary state: active enables and frame counter
  // --------------------------------------------------------------------------
  logic [NUM_LAYERS-1:0] en_act;
  logic [15:0]           frame_cnt;

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      en_act    <= '0;
      frame_cnt <= 16'd0;
    end else if (vs_fall) begin
      en_act    <= layer_en_req;
      frame_cnt <= frame_cnt + 16'd1;
    end
  end

  assign frame_count = frame_cnt;

  // --------------------------------------------------------------------------
  // Priority select: lowest-index opaque, enabled layer wins.
  // Scanning from the top index down lets lower indices overwrite the result.
  // --------------------------------------------------------------------------
  logic [IDX_W-1:0] win_idx;
  logic [11:0]      win_rgb;

  always_comb begin
    win_idx = BG_IDX;
    win_rgb = bg_rgb;
    for (int k = NUM_LAYERS - 1; k >= 0; k--) begin
      if (a_q[k] && en_act[k]) begin
        win_idx = IDX_W'(k);
        win_rgb = layer_rgb[12*k +: 12];
      end
    end
  end

  // --------------------------------------------------------------------------
  // Hit flash
  // --------------------------------------------------------------------------
  logic [3:0] red_sel;

`ifdef SPRITE_MIXER_FLASH_EN
  logic [3:0] flash_cnt;
  logic [4:0] red_sum;

  // A new request always reloads, including on a frame edge.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      flash_cnt <= 4'd0;
    end else if (flash_req) begin
      flash_cnt <= 4'(FLASH_FRAMES);
    end else if (vs_fall && (flash_cnt != 4'd0)) begin
      flash_cnt <= flash_cnt - 4'd1;
    end
  end

  // Saturating +6 on red only.
  assign red_sum = {1'b0, win_rgb[11:8]} + 5'd6;
  assign red_sel = (flash_cnt == 4'd0) ? win_rgb[11:8]
                 : (red_sum[4] ? 4'hF : red_sum[3:0]);
`else
  logic unused_flash_req;
  assign unused_flash_req = flash_req;
  assign red_sel          = win_rgb[11:8];
`endif

  // --------------------------------------------------------------------------
  // Stage 2: registered VGA outputs
  // --------------------------------------------------------------------------
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      red       <= 4'd0;
      green     <= 4'd0;
      blue      <= 4'd0;
      hs_out    <= 1'b1;
      vs_out    <= 1'b1;
      blank_out <= 1'b0;
      top_layer <= BG_IDX;
    end else begin
      hs_out    <= hs_t1;
      vs_out    <= vs_q;
      blank_out <= blank_t1;
      if (blank_t1) begin
        red       <= red_sel;
        green     <= win_rgb[7:4];
        blue      <= win_rgb[3:0];
        top_layer <= win_idx;
      end else begin
        // Colour must be black outside active video for the DAC.
        red       <= 4'd0;
        green     <= 4'd0;
        blue      <= 4'd0;
        top_layer <= BG_IDX;
      end
    end
  end

endmodule
`default_nettype wire
